safe_wrapper_csr: RTL and testbench

- Control/status register block for the safe CPU wrapper.
- Sits directly downstream of the bus system's 2-port register mux (CSR output port).
- Serves register accesses from the cores and from the external CSR master.
- Runs a hart-synchronisation FSM (halt harts → wait halted → sync pulse → release) that switches lockstep mode (single/DMR/TMR) and the common boot address.

---
 rtl/safe_wrapper_csr.sv | 181 ++++++++++++++++++
 tb/tb_safe_wrapper_csr.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/safe_wrapper_csr.sv
// Control/status registers for the safe CPU wrapper plus the hart halt/sync
// sequencer that switches lockstep mode and the common boot address.

package reg_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module safe_wrapper_csr #(
  parameter int unsigned NHARTS      = 3,
  parameter logic [15:0] TIMEOUT_RST = 16'h0400
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  reg_pkg::reg_req_t   reg_req_i,
  output reg_pkg::reg_rsp_t   reg_rsp_o,
  input  logic [NHARTS-1:0]   hart_halted_i,
  output logic [NHARTS-1:0]   halt_req_o,
  output logic                sync_o,
  output logic [31:0]         boot_addr_o,
  output logic [1:0]          mode_o,
  output logic                intr_o
);
  // state   | meaning
  // IDLE    | waiting for START
  // HALT    | halt requested on targeted harts; wait for all halted or timeout
  // SYNC    | one-cycle sync pulse; requested mode is latched
  // RELEASE | halt requests dropped; DONE set on exit
  // ABORT   | timeout hit; halt requests dropped; ERR set on exit
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HALT    = 3'd1,
    S_SYNC    = 3'd2,
    S_RELEASE = 3'd3,
    S_ABORT   = 3'd4
  } state_e;

  localparam logic [2:0] OFF_CONFIG  = 3'd0;
  localparam logic [2:0] OFF_CTRL    = 3'd1;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_BOOT    = 3'd3;
  localparam logic [2:0] OFF_TIMEOUT = 3'd4;
  localparam logic [2:0] OFF_HALTED  = 3'd5;

  state_e            state_q, state_d;
  logic [1:0]        mode_req_q;
  logic [15:0]       timeout_q, cnt_q;
  logic              done_q, err_q, ie_done_q, ie_err_q;
  logic [NHARTS-1:0] mask;
  logic              all_halted, busy;
  logic [2:0]        offset;
  logic              wr, rd, bad_off, wr_err, acc_err, we;
  logic              we_cfg, we_status, we_boot, we_tmo, start;
  logic [31:0]       rdata;
  logic              unused_addr;

  assign unused_addr = ^{reg_req_i.addr[31:5], reg_req_i.addr[1:0]};

  // Only harts 0..2 ever take part in lockstep.
  always_comb begin
    mask    = '0;
    mask[0] = 1'b1;
    mask[1] = (mode_req_q != 2'd0);
    mask[2] = (mode_req_q == 2'd2);
  end

  assign all_halted = ((hart_halted_i & mask) == mask);
  assign busy       = (state_q != S_IDLE);

  assign offset  = reg_req_i.addr[4:2];
  assign wr      = reg_req_i.valid & reg_req_i.write;
  assign rd      = reg_req_i.valid & ~reg_req_i.write;
  assign bad_off = (offset > OFF_HALTED);

  always_comb begin
    wr_err = 1'b0;
    if (wr) begin
      case (offset)
        OFF_CONFIG: wr_err = busy | (reg_req_i.wstrb[0] & (reg_req_i.wdata[1:0] == 2'd3));
        OFF_BOOT:   wr_err = busy;
        default:    wr_err = 1'b0;
      endcase
    end
  end

  assign acc_err   = reg_req_i.valid & (bad_off | wr_err);
  assign we        = wr & ~acc_err;
  assign we_cfg    = we & (offset == OFF_CONFIG) & reg_req_i.wstrb[0];
  assign we_status = we & (offset == OFF_STATUS) & reg_req_i.wstrb[0];
  assign we_boot   = we & (offset == OFF_BOOT);
  assign we_tmo    = we & (offset == OFF_TIMEOUT);
  assign start     = we & (offset == OFF_CTRL) & reg_req_i.wstrb[0] & reg_req_i.wdata[0] & ~busy;

  always_comb begin
    rdata = '0;
    if (rd && !bad_off) begin
      case (offset)
        OFF_CONFIG:  rdata[1:0]        = mode_req_q;
        OFF_STATUS:  rdata[6:0]        = {ie_err_q, ie_done_q, err_q, done_q, state_q};
        OFF_BOOT:    rdata             = boot_addr_o;
        OFF_TIMEOUT: rdata[15:0]       = timeout_q;
        OFF_HALTED:  rdata[NHARTS-1:0] = hart_halted_i;
        default:     rdata             = '0;
      endcase
    end
  end

  assign reg_rsp_o.rdata = rdata;
  assign reg_rsp_o.error = acc_err;
  assign reg_rsp_o.ready = reg_req_i.valid;

  // Halted takes priority over the timeout compare on the same cycle.
  always_comb begin
    state_d    = state_q;
    halt_req_o = '0;
    sync_o     = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_HALT;
      S_HALT: begin
        halt_req_o = mask;
        if (all_halted)                                state_d = S_SYNC;
        else if (timeout_q != 16'd0 && cnt_q == timeout_q) state_d = S_ABORT;
      end
      S_SYNC: begin
        halt_req_o = mask;
        sync_o     = 1'b1;
        state_d    = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      S_ABORT:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_o      <= '0;
      mode_req_q  <= '0;
      timeout_q   <= TIMEOUT_RST;
      boot_addr_o <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ie_done_q   <= 1'b0;
      ie_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == S_HALT) ? cnt_q + 16'd1 : 16'd0;
      if (state_q == S_SYNC) mode_o <= mode_req_q;
      if (we_cfg) mode_req_q <= reg_req_i.wdata[1:0];
      if (we_tmo && reg_req_i.wstrb[0]) timeout_q[7:0]  <= reg_req_i.wdata[7:0];
      if (we_tmo && reg_req_i.wstrb[1]) timeout_q[15:8] <= reg_req_i.wdata[15:8];
      for (int b = 0; b < 4; b++) begin
        if (we_boot && reg_req_i.wstrb[b]) boot_addr_o[8*b +: 8] <= reg_req_i.wdata[8*b +: 8];
      end
      if (we_status) begin
        ie_done_q <= reg_req_i.wdata[5];
        ie_err_q  <= reg_req_i.wdata[6];
      end
      if (state_q == S_RELEASE)                 done_q <= 1'b1;
      else if (we_status && reg_req_i.wdata[3]) done_q <= 1'b0;
      if (state_q == S_ABORT)                   err_q <= 1'b1;
      else if (we_status && reg_req_i.wdata[4]) err_q <= 1'b0;
    end
  end

  assign intr_o = (done_q & ie_done_q) | (err_q & ie_err_q);

endmodule

// File: tb/tb_safe_wrapper_csr.sv
// Self-checking bench for safe_wrapper_csr: directed scenarios plus randomized
// register traffic and randomized halt/sync sequences against a register-level model.

module tb_safe_wrapper_csr;
  localparam int NH = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  reg_pkg::reg_req_t req;
  reg_pkg::reg_rsp_t rsp;
  logic [NH-1:0]     halted;
  logic [NH-1:0]     halt_req;
  logic              sync;
  logic [31:0]       boot;
  logic [1:0]        mode;
  logic              intr;

  int vectors = 0;
  int errors  = 0;

  logic [1:0]  m_mode_req, m_mode;
  logic [31:0] m_boot;
  logic [15:0] m_tmo;
  logic        m_done, m_err, m_ie_done, m_ie_err;

  safe_wrapper_csr #(.NHARTS(NH), .TIMEOUT_RST(16'h0400)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .reg_req_i    (req),
    .reg_rsp_o    (rsp),
    .hart_halted_i(halted),
    .halt_req_o   (halt_req),
    .sync_o       (sync),
    .boot_addr_o  (boot),
    .mode_o       (mode),
    .intr_o       (intr)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_mode_req = 2'd0; m_mode = 2'd0; m_boot = 32'd0; m_tmo = 16'h0400;
    m_done = 1'b0; m_err = 1'b0; m_ie_done = 1'b0; m_ie_err = 1'b0;
  endtask

  function automatic logic exp_intr();
    return (m_done & m_ie_done) | (m_err & m_ie_err);
  endfunction

  // Expected response of one access while the sequencer is idle; applies write effects.
  task automatic model_access(input logic wr, input logic [2:0] off, input logic [31:0] wd,
                              input logic [3:0] ws, input logic [NH-1:0] hh,
                              output logic [31:0] erd, output logic eerr);
    eerr = (off > 3'd5) || (wr && off == 3'd0 && ws[0] && wd[1:0] == 2'd3);
    erd  = 32'd0;
    if (!wr && !eerr) begin
      case (off)
        3'd0: erd = {30'd0, m_mode_req};
        3'd2: erd = {25'd0, m_ie_err, m_ie_done, m_err, m_done, 3'd0};
        3'd3: erd = m_boot;
        3'd4: erd = {16'd0, m_tmo};
        3'd5: erd = 32'(hh);
        default: erd = 32'd0;
      endcase
    end
    if (wr && !eerr) begin
      case (off)
        3'd0: if (ws[0]) m_mode_req = wd[1:0];
        3'd2: if (ws[0]) begin
          if (wd[3]) m_done = 1'b0;
          if (wd[4]) m_err = 1'b0;
          m_ie_done = wd[5];
          m_ie_err  = wd[6];
        end
        3'd3: for (int b = 0; b < 4; b++) if (ws[b]) m_boot[8*b +: 8] = wd[8*b +: 8];
        3'd4: for (int b = 0; b < 2; b++) if (ws[b]) m_tmo[8*b +: 8] = wd[8*b +: 8];
        default: ;
      endcase
    end
  endtask

  // One single-cycle access: drive at negedge, sample response, commit on posedge.
  task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] ws, output logic [31:0] rd, output logic er,
                     output logic rdy);
    @(negedge clk_i);
    req.valid = 1'b1; req.write = wr; req.addr = addr; req.wdata = wd; req.wstrb = ws;
    #1;
    rd = rsp.rdata; er = rsp.error; rdy = rsp.ready;
    @(posedge clk_i);
    #1;
    req.valid = 1'b0; req.write = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] off, input logic [31:0] data);
    logic [31:0] rd, erd;
    logic er, rdy, eer;
    model_access(1'b1, off, data, 4'hF, halted, erd, eer);
    bus(1'b1, {27'd0, off, 2'b00}, data, 4'hF, rd, er, rdy);
    vectors++;
    if (er !== eer || rdy !== 1'b1 || rd !== erd) begin
      errors++;
      $display("FAIL cfg_write off=%0d: err=%b ready=%b rdata=%h, expected err=%b ready=1 rdata=%h",
               off, er, rdy, rd, eer, erd);
    end
  endtask

  task automatic start_fsm();
    logic [31:0] rd;
    logic er, rdy;
    bus(1'b1, 32'h4, 32'h1, 4'hF, rd, er, rdy);
    vectors++;
    if (er !== 1'b0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL start: err=%b rdata=%h, expected err=0 rdata=0", er, rd);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic er, rdy;
    logic [2:0]  offs [4] = '{3'd0, 3'd2, 3'd3, 3'd4};
    logic [31:0] exps [4] = '{32'h0, 32'h0, 32'h0, 32'h400};
    #3;
    vectors++;
    if ({halt_req, sync, boot, mode, intr} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: halt_req=%b sync=%b boot=%h mode=%0d intr=%b, expected all 0",
               halt_req, sync, boot, mode, intr);
    end
    @(negedge clk_i); #2 rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, {27'd0, offs[i], 2'b01}, 32'd0, 4'h0, rd, er, rdy);
      vectors++;
      if (rd !== exps[i] || er !== 1'b0 || rdy !== 1'b1) begin
        errors++;
        $display("FAIL reset_read off=%0d: rdata=%h err=%b ready=%b, expected rdata=%h err=0 ready=1",
                 offs[i], rd, er, rdy, exps[i]);
      end
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd, erd;
    logic er, rdy, eer;
    cfg_write(3'd3, 32'h1122_3344);
    model_access(1'b1, 3'd3, 32'hAABB_CCDD, 4'b0101, halted, erd, eer);
    bus(1'b1, 32'hC, 32'hAABB_CCDD, 4'b0101, rd, er, rdy);
    bus(1'b0, 32'hC, 32'd0, 4'h0, rd, er, rdy);
    vectors++;
    if (rd !== 32'h11BB_33DD || boot !== 32'h11BB_33DD || m_boot !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL strobes: read=%h boot_addr_o=%h, expected 11bb33dd", rd, boot);
    end
  endtask

  task automatic test_sync_sequence();
    logic [31:0] rd, erd;
    logic er, rdy, eer;
    int hcnt, scnt, first;
    halted = '0;
    cfg_write(3'd0, 32'd2);
    cfg_write(3'd3, 32'h0000_1080);
    cfg_write(3'd2, 32'h20);
    start_fsm();
    vectors++;
    if (halt_req !== 3'b111) begin
      errors++;
      $display("FAIL sync_halt_req: halt_req=%b, expected 111", halt_req);
    end
    hcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (halt_req === 3'b111 && sync === 1'b0) hcnt++;
    end
    vectors++;
    if (hcnt != 5) begin
      errors++;
      $display("FAIL sync_halt_hold: cycles=%0d, expected 5", hcnt);
    end
    halted = 3'b111;
    scnt = 0; first = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      if (sync === 1'b1) begin
        scnt++;
        if (first < 0) first = i;
      end
    end
    m_mode = 2'd2; m_done = 1'b1;
    vectors++;
    if (scnt != 1 || first != 1) begin
      errors++;
      $display("FAIL sync_pulse: high_cycles=%0d first=%0d, expected 1 and 1", scnt, first);
    end
    vectors++;
    if (mode !== 2'd2 || boot !== 32'h1080 || intr !== 1'b1 || halt_req !== 3'b000) begin
      errors++;
      $display("FAIL sync_result: mode=%0d boot=%h intr=%b halt_req=%b, expected 2 00001080 1 000",
               mode, boot, intr, halt_req);
    end
    model_access(1'b0, 3'd2, 32'd0, 4'h0, halted, erd, eer);
    bus(1'b0, 32'h8, 32'd0, 4'h0, rd, er, rdy);
    vectors++;
    if (rd !== erd || rd !== 32'h28) begin
      errors++;
      $display("FAIL sync_status: rdata=%h, expected %h", rd, erd);
    end
    cfg_write(3'd2, 32'h08);
    vectors++;
    if (intr !== 1'b0) begin
      errors++;
      $display("FAIL sync_w1c: intr=%b, expected 0", intr);
    end
    halted = '0;
  endtask

  task automatic test_timeout_abort();
    logic [31:0] rd, erd;
    logic er, rdy, eer;
    int hcnt;
    halted = 3'b001;
    cfg_write(3'd0, 32'd1);
    cfg_write(3'd4, 32'd4);
    cfg_write(3'd2, 32'h40);
    start_fsm();
    hcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (halt_req === 3'b011) hcnt++;
    end
    m_err = 1'b1;
    vectors++;
    if (hcnt != 5) begin
      errors++;
      $display("FAIL abort_halt_cycles: cycles=%0d, expected 5", hcnt);
    end
    vectors++;
    if (mode !== m_mode || intr !== 1'b1 || halt_req !== 3'b000) begin
      errors++;
      $display("FAIL abort_outputs: mode=%0d intr=%b halt_req=%b, expected %0d 1 000",
               mode, intr, halt_req, m_mode);
    end
    model_access(1'b0, 3'd2, 32'd0, 4'h0, halted, erd, eer);
    bus(1'b0, 32'h8, 32'd0, 4'h0, rd, er, rdy);
    vectors++;
    if (rd !== erd || rd !== 32'h50) begin
      errors++;
      $display("FAIL abort_status: rdata=%h, expected %h", rd, erd);
    end
    halted = '0;
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic er, rdy;
    bus(1'b1, 32'h0, 32'd3, 4'hF, rd, er, rdy);
    vectors++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL cfg3_err: err=%b rdata=%h, expected err=1 rdata=0", er, rd);
    end
    bus(1'b0, 32'h0, 32'd0, 4'h0, rd, er, rdy);
    vectors++;
    if (rd !== {30'd0, m_mode_req} || er !== 1'b0) begin
      errors++;
      $display("FAIL cfg3_unchanged: rdata=%h, expected %h", rd, {30'd0, m_mode_req});
    end
    bus(1'b0, 32'h18, 32'd0, 4'h0, rd, er, rdy);
    vectors++;
    if (er !== 1'b1 || rd !== 32'd0 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL bad_offset: err=%b rdata=%h ready=%b, expected 1 0 1", er, rd, rdy);
    end
    cfg_write(3'd4, 32'd0);
    halted = '0;
    start_fsm();
    bus(1'b1, 32'hC, 32'hDEAD_BEEF, 4'hF, rd, er, rdy);
    vectors++;
    if (er !== 1'b1 || boot !== m_boot) begin
      errors++;
      $display("FAIL boot_busy: err=%b boot=%h, expected err=1 boot=%h", er, boot, m_boot);
    end
    bus(1'b1, 32'h0, 32'd2, 4'hF, rd, er, rdy);
    bus(1'b0, 32'h8, 32'd0, 4'h0, rd, er, rdy);
    vectors++;
    if (rd[2:0] !== 3'd1) begin
      errors++;
      $display("FAIL busy_state: state=%0d, expected 1", rd[2:0]);
    end
  endtask

  task automatic test_reset_in_halt();
    logic [31:0] rd;
    logic er, rdy;
    @(negedge clk_i); #2 rst_ni = 1'b0;
    #1;
    vectors++;
    if (halt_req !== '0 || sync !== 1'b0 || mode !== 2'd0) begin
      errors++;
      $display("FAIL rst_halt: halt_req=%b sync=%b mode=%0d, expected 000 0 0", halt_req, sync, mode);
    end
    @(negedge clk_i); #2 rst_ni = 1'b1;
    model_reset();
    bus(1'b0, 32'h8, 32'd0, 4'h0, rd, er, rdy);
    vectors++;
    if (rd !== 32'd0 || mode !== 2'd0 || halt_req !== '0) begin
      errors++;
      $display("FAIL rst_after: status=%h mode=%0d halt_req=%b, expected 0 0 000", rd, mode, halt_req);
    end
    bus(1'b0, 32'h10, 32'd0, 4'h0, rd, er, rdy);
    vectors++;
    if (rd !== 32'h400) begin
      errors++;
      $display("FAIL rst_timeout: rdata=%h, expected 00000400", rd);
    end
  endtask

  task automatic test_random_regs();
    logic [31:0] rd, erd, wd, tmp;
    logic er, rdy, eer, wr;
    logic [2:0] off;
    logic [3:0] ws;
    for (int n = 0; n < 200; n++) begin
      off = 3'($urandom_range(0, 7));
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      ws  = 4'($urandom_range(0, 15));
      if (off == 3'd1) wd[0] = 1'b0;
      tmp = $urandom;
      halted = NH'($urandom);
      model_access(wr, off, wd, ws, halted, erd, eer);
      bus(wr, {tmp[31:5], off, tmp[1:0]}, wd, ws, rd, er, rdy);
      vectors++;
      if (rd !== erd || er !== eer || rdy !== 1'b1) begin
        errors++;
        $display("FAIL rand_access n=%0d off=%0d wr=%b: rdata=%h err=%b ready=%b, expected %h %b 1",
                 n, off, wr, rd, er, rdy, erd, eer);
      end
      vectors++;
      if (boot !== m_boot || intr !== exp_intr() || mode !== m_mode || halt_req !== '0) begin
        errors++;
        $display("FAIL rand_outputs n=%0d: boot=%h intr=%b mode=%0d, expected %h %b %0d",
                 n, boot, intr, mode, m_boot, exp_intr(), m_mode);
      end
    end
    halted = '0;
  endtask

  task automatic test_random_sequences();
    logic [31:0] rd, erd;
    logic er, rdy, eer;
    logic [NH-1:0] mask;
    int m, t, d, hcnt, scnt, exp_h;
    bit success;
    for (int n = 0; n < 20; n++) begin
      m = $urandom_range(0, 2);
      t = $urandom_range(0, 8);
      d = $urandom_range(0, 12);
      mask = NH'((1 << (m + 1)) - 1);
      halted = NH'($urandom) & ~mask;
      cfg_write(3'd0, 32'(m));
      cfg_write(3'd4, 32'(t));
      cfg_write(3'd2, {25'd0, 2'($urandom_range(0, 3)), 5'd0});
      start_fsm();
      hcnt = 0; scnt = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk_i);
        if (halt_req === mask) hcnt++;
        if (sync === 1'b1) scnt++;
        if (i == d) halted = mask | NH'($urandom);
      end
      success = (t == 0) || (d <= t);
      exp_h   = success ? d + 2 : t + 1;
      if (success) begin
        m_mode = 2'(m); m_done = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      vectors++;
      if (hcnt != exp_h || scnt != (success ? 1 : 0)) begin
        errors++;
        $display("FAIL rand_seq n=%0d m=%0d t=%0d d=%0d: halt_cycles=%0d syncs=%0d, expected %0d %0d",
                 n, m, t, d, hcnt, scnt, exp_h, success ? 1 : 0);
      end
      vectors++;
      if (mode !== m_mode || intr !== exp_intr() || halt_req !== '0) begin
        errors++;
        $display("FAIL rand_seq_out n=%0d: mode=%0d intr=%b halt_req=%b, expected %0d %b 0",
                 n, mode, intr, halt_req, m_mode, exp_intr());
      end
      model_access(1'b0, 3'd2, 32'd0, 4'h0, halted, erd, eer);
      bus(1'b0, 32'h8, 32'd0, 4'h0, rd, er, rdy);
      vectors++;
      if (rd !== erd) begin
        errors++;
        $display("FAIL rand_seq_status n=%0d: rdata=%h, expected %h", n, rd, erd);
      end
      cfg_write(3'd2, 32'h18);
      halted = '0;
    end
  endtask

  initial begin
    req = '0;
    halted = '0;
    model_reset();
    test_reset();
    test_strobes();
    test_sync_sequence();
    test_timeout_abort();
    test_errors();
    test_reset_in_halt();
    test_random_regs();
    test_random_sequences();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
